wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 8x16 register file.
- Merges two producers into the file's single write port (write/writeregsel/writedata):
  - ALU results, which can be back-pressured.
  - Load data from memory, which has fixed priority and cannot stall.
- ALU results that lose arbitration wait in a small FIFO.
- An older buffered ALU write to a register is killed when a load writes the same register, so program-order WAW semantics hold.

Parameters:
DEPTH, 4, ALU buffer entries; power of 2, >=2
DW, 16, data width
RW, 3, register select width

Ports:
clk  in  1  clock
rst  in  1  reset; active-low, synchronous (sampled at posedge clk)
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
alu_reg  in  RW  ALU destination register
alu_data  in  DW  ALU result
mem_valid  in  1  load result valid; always accepted
mem_reg  in  RW  load destination register
mem_data  in  DW  load data
write  out  1  register-file write enable (registered)
writeregsel  out  RW  register-file write select (registered)
writedata  out  DW  register-file write data (registered)
pend_count  out  $clog2(DEPTH)+1  live FIFO occupancy
squash  out  1  one-cycle pulse: >=1 FIFO entry killed this cycle
err  out  1  sticky protocol error
fwd_sel  in  RW  forwarding lookup select
fwd_hit  out  1  forwarding hit
fwd_data  out  DW  forwarding value

Behaviour:
- Reset: rst==0 at posedge clears FIFO pointers and valid bits. write=0, writeregsel=0, writedata=0, squash=0, err=0, pend_count=0. Reset mid-operation discards all pending entries with no write issued.
- alu_ready = !full (combinational on FIFO state only). There is no mem_ready: mem is always accepted.
- Per-cycle selection, in priority order; the selected write appears on write/writeregsel/writedata at the next posedge (1-cycle latency). Otherwise write=0 next cycle, and writeregsel/writedata hold their last values.
  1. mem_valid: issue mem write.
  2. FIFO non-empty: pop head. If the head is live, issue it; if killed, pop it with no write.
  3. FIFO empty and alu_valid: issue ALU directly (bypass; not enqueued).
- ALU enqueue: alu_valid && alu_ready and the ALU was not issued directly → push at tail, live=1.
- Full FIFO with a simultaneous pop: alu_ready stays 0 that cycle. No push-on-pop.
- Kill rule, on an accepted mem write:
  - Every FIFO entry, existing before this cycle, whose reg==mem_reg has its live bit cleared.
  - An ALU result accepted in the same cycle is younger than the mem write and is never killed.
  - squash=1 for the following cycle iff >=1 entry was killed.
- Ordering: live FIFO writes retire in FIFO order. An ALU result cannot bypass while the FIFO is non-empty.
- pend_count = number of live entries (killed entries are excluded). Registered, updated with FIFO state.
- err is set (sticky until reset) when either:
  - alu_valid falls without acceptance (alu_valid=1 && alu_ready=0, then alu_valid=0 next cycle); or
  - alu_reg/alu_data change while alu_valid is held and unaccepted.
  The last offered ALU transaction is registered for this check. err does not alter datapath behaviour.
- Pointer wrap: head/tail wrap modulo DEPTH. Full/empty is distinguished by an extra pointer bit.

Optional Feature:
- WB_FWD_EN defined:
  - fwd_hit=1 when any live FIFO entry, or a pending output write (write=1), targets fwd_sel.
  - fwd_data returns the youngest such value, in priority order: newest FIFO entry, then older entries, then the output register.
  - Fully combinational.
- WB_FWD_EN undefined: fwd_hit=0 and fwd_data=0 constant. No compare logic is built.

Test Plan:
- ALU only, FIFO empty: alu_valid=1, reg=3, data=16'h1234 → alu_ready=1; next cycle write=1, writeregsel=3, writedata=16'h1234; pend_count stays 0.
- Contention: mem (reg 1, 16'hAAAA) and ALU (reg 2, 16'h5555) in the same cycle → cycle+1 writes reg 1=AAAA; cycle+2 writes reg 2=5555; pend_count =1 for exactly one cycle.
- Fill/full: mem_valid held high for 6 cycles while 6 ALU results are offered →
  - alu_ready drops after 4 accepts; pend_count=4.
  - After mem stops, 4 ALU writes retire in order; then the remaining 2 are accepted and issued.
- WAW kill: buffer ALU reg 5=16'h0001, then a mem write reg 5=16'h0002 →
  - squash pulses once.
  - reg 5 is written only with 16'h0002.
  - The killed pop produces a cycle with write=0.
- Reset mid-flight: 3 entries buffered, rst=0 for one cycle → write=0, pend_count=0, alu_ready=1; no buffered data is ever written.
- Protocol violation and forwarding:
  - err: alu_valid=1 while full, then drop alu_valid → err=1 and remains 1 until rst=0.
  - With WB_FWD_EN: two buffered reg 4 entries (16'h0010, then 16'h0020) with fwd_sel=4 → fwd_hit=1, fwd_data=16'h0020.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges non-stallable load data and back-pressured ALU results into one
// register-file write port. Define WB_FWD_EN to build the forwarding lookup over pending writes.

module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned RW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [RW-1:0]          alu_reg,
    input  logic [DW-1:0]          alu_data,
    input  logic                   mem_valid,
    input  logic [RW-1:0]          mem_reg,
    input  logic [DW-1:0]          mem_data,
    output logic                   write,
    output logic [RW-1:0]          writeregsel,
    output logic [DW-1:0]          writedata,
    output logic [$clog2(DEPTH):0] pend_count,
    output logic                   squash,
    output logic                   err,
    input  logic [RW-1:0]          fwd_sel,
    output logic                   fwd_hit,
    output logic [DW-1:0]          fwd_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DepthCnt = (PW+1)'(DEPTH);

    logic [PW:0]      wptr_q, rptr_q, occ;
    logic [PW-1:0]    head, tail;
    logic [DEPTH-1:0] live_q, live_d, kill_vec;
    logic [RW-1:0]    reg_q  [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PW:0]      pend_d, pend_q;

    logic             full, empty, pop, bypass, push;
    logic             wr_en;
    logic [RW-1:0]    wr_sel;
    logic [DW-1:0]    wr_data;

    logic             write_q, squash_q, err_q;
    logic [RW-1:0]    writeregsel_q;
    logic [DW-1:0]    writedata_q;

    logic             prev_valid_q, prev_ready_q;
    logic [RW-1:0]    prev_reg_q;
    logic [DW-1:0]    prev_data_q;

    assign occ   = wptr_q - rptr_q;
    assign full  = (occ == DepthCnt);
    assign empty = (wptr_q == rptr_q);
    assign head  = rptr_q[PW-1:0];
    assign tail  = wptr_q[PW-1:0];

    assign alu_ready = !full;

    always_comb begin
        pop    = !mem_valid && !empty;
        bypass = !mem_valid && empty && alu_valid;
        push   = alu_valid && alu_ready && !bypass;

        // Only entries already buffered can be killed; a same-cycle push is younger.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kill_vec[i] = mem_valid && live_q[i] && (reg_q[i] == mem_reg);
        end

        live_d = live_q & ~kill_vec;
        if (pop) begin
            live_d[head] = 1'b0;
        end
        if (push) begin
            live_d[tail] = 1'b1;
        end

        pend_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_d = pend_d + (PW+1)'(live_d[i]);
        end

        wr_en   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        if (mem_valid) begin
            wr_en   = 1'b1;
            wr_sel  = mem_reg;
            wr_data = mem_data;
        end else if (pop) begin
            wr_en   = live_q[head];
            wr_sel  = reg_q[head];
            wr_data = data_q[head];
        end else if (bypass) begin
            wr_en   = 1'b1;
            wr_sel  = alu_reg;
            wr_data = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            live_q        <= '0;
            pend_q        <= '0;
            write_q       <= 1'b0;
            writeregsel_q <= '0;
            writedata_q   <= '0;
            squash_q      <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + (PW+1)'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + (PW+1)'(1);
            end
            live_q   <= live_d;
            pend_q   <= pend_d;
            write_q  <= wr_en;
            squash_q <= |kill_vec;
            if (wr_en) begin
                writeregsel_q <= wr_sel;
                writedata_q   <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[tail]  <= alu_reg;
            data_q[tail] <= alu_data;
        end
    end

    // Last offered ALU transaction, used only to flag handshake violations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_ready_q <= 1'b0;
            prev_reg_q   <= '0;
            prev_data_q  <= '0;
        end else begin
            if (prev_valid_q && !prev_ready_q &&
                (!alu_valid || alu_reg != prev_reg_q || alu_data != prev_data_q)) begin
                err_q <= 1'b1;
            end
            prev_valid_q <= alu_valid;
            prev_ready_q <= alu_ready;
            prev_reg_q   <= alu_reg;
            prev_data_q  <= alu_data;
        end
    end

    assign write       = write_q;
    assign writeregsel = writeregsel_q;
    assign writedata   = writedata_q;
    assign pend_count  = pend_q;
    assign squash      = squash_q;
    assign err         = err_q;

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (write_q && writeregsel_q == fwd_sel) begin
            fwd_hit  = 1'b1;
            fwd_data = writedata_q;
        end
        // Walk oldest to newest so the youngest match wins.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (live_q[fwd_idx] && reg_q[fwd_idx] == fwd_sel) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^fwd_sel;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle, directed scenarios with
// literal expectations, then randomized traffic including handshake violations and resets.

module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int RW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [RW-1:0] alu_reg = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic [RW-1:0] mem_reg = '0;
    logic [DW-1:0] mem_data = '0;
    logic          write;
    logic [RW-1:0] writeregsel;
    logic [DW-1:0] writedata;
    logic [2:0]    pend_count;
    logic          squash;
    logic          err;
    logic [RW-1:0] fwd_sel = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .write      (write),
        .writeregsel(writeregsel),
        .writedata  (writedata),
        .pend_count (pend_count),
        .squash     (squash),
        .err        (err),
        .fwd_sel    (fwd_sel),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending ALU results as a program-ordered queue.
    typedef struct {
        logic [RW-1:0] r;
        logic [DW-1:0] d;
        bit            live;
    } ent_t;

    ent_t          mq[$];
    logic          e_write, e_squash, e_err;
    logic [RW-1:0] e_sel;
    logic [DW-1:0] e_data;
    int            e_pend;
    bit            pv, pr;
    logic [RW-1:0] preg;
    logic [DW-1:0] pdata;

    always @(posedge clk) begin
        bit   ready, byp, kill;
        ent_t h;
        if (!rst) begin
            mq.delete();
            e_write = 0; e_sel = '0; e_data = '0; e_squash = 0; e_err = 0; e_pend = 0;
            pv = 0; pr = 0; preg = '0; pdata = '0;
        end else begin
            ready = (mq.size() < DEPTH);
            if (pv && !pr && (!alu_valid || alu_reg !== preg || alu_data !== pdata)) e_err = 1;
            pv = alu_valid; pr = ready; preg = alu_reg; pdata = alu_data;
            kill = 0; byp = 0; e_write = 0;
            if (mem_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].live && mq[i].r == mem_reg) begin
                        mq[i].live = 0;
                        kill = 1;
                    end
                end
                e_write = 1; e_sel = mem_reg; e_data = mem_data;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.live) begin
                    e_write = 1; e_sel = h.r; e_data = h.d;
                end
            end else if (alu_valid) begin
                byp = 1;
                e_write = 1; e_sel = alu_reg; e_data = alu_data;
            end
            if (alu_valid && ready && !byp) mq.push_back('{alu_reg, alu_data, 1'b1});
            e_squash = kill;
            e_pend = 0;
            foreach (mq[i]) if (mq[i].live) e_pend++;
        end
    end

    logic [RW+DW-1:0] wlog[$];

    always @(negedge clk) begin
        logic          eh;
        logic [DW-1:0] ed;
        if (chk_en) begin
            check("write", write, e_write);
            check("writeregsel", writeregsel, e_sel);
            check("writedata", writedata, e_data);
            check("pend_count", pend_count, e_pend);
            check("squash", squash, e_squash);
            check("err", err, e_err);
            check("alu_ready", alu_ready, mq.size() < DEPTH);
            eh = 0; ed = '0;
`ifdef WB_FWD_EN
            if (e_write && e_sel == fwd_sel) begin eh = 1; ed = e_data; end
            foreach (mq[i]) if (mq[i].live && mq[i].r == fwd_sel) begin eh = 1; ed = mq[i].d; end
`endif
            check("fwd_hit", fwd_hit, eh);
            check("fwd_data", fwd_data, ed);
            if (write) wlog.push_back({writeregsel, writedata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        alu_valid = 0;
        mem_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int k, cyc, cnt;
        bit acc, held;
        logic [RW+DW-1:0] w;

        rst = 0;
        tick(); tick();
        rst = 1;
        chk_en = 1;
        check("rst_write", write, 0);
        check("rst_sel", writeregsel, 0);
        check("rst_data", writedata, 0);
        check("rst_pend", pend_count, 0);
        check("rst_squash", squash, 0);
        check("rst_err", err, 0);
        check("rst_ready", alu_ready, 1);

        // ALU only, bypass path
        alu_valid = 1; alu_reg = 3; alu_data = 16'h1234;
        check("byp_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        check("byp_write", write, 1);
        check("byp_sel", writeregsel, 3);
        check("byp_data", writedata, 16'h1234);
        check("byp_pend", pend_count, 0);
        idle(2);

        // Contention
        mem_valid = 1; mem_reg = 1; mem_data = 16'hAAAA;
        alu_valid = 1; alu_reg = 2; alu_data = 16'h5555;
        tick();
        mem_valid = 0; alu_valid = 0;
        check("cont1_sel", writeregsel, 1);
        check("cont1_data", writedata, 16'hAAAA);
        check("cont1_pend", pend_count, 1);
        tick();
        check("cont2_write", write, 1);
        check("cont2_sel", writeregsel, 2);
        check("cont2_data", writedata, 16'h5555);
        check("cont2_pend", pend_count, 0);
        idle(2);

        // Fill to full while loads hold the port
        wlog.delete();
        k = 0; cyc = 0;
        while (k < 6 && cyc < 40) begin
            if (cyc == 4) begin
                check("full_ready", alu_ready, 0);
                check("full_pend", pend_count, 4);
            end
            mem_valid = (cyc < 6); mem_reg = 0; mem_data = DW'(cyc);
            alu_valid = 1; alu_reg = RW'(k + 1); alu_data = DW'(16'h0100 + k);
            acc = alu_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        check("fill_accepts", k, 6);
        idle(8);
        cnt = 0;
        foreach (wlog[i]) begin
            w = wlog[i];
            if (w[RW+DW-1:DW] != 0) begin
                check("fill_order_sel", w[RW+DW-1:DW], cnt + 1);
                check("fill_order_data", w[DW-1:0], 16'h0100 + cnt);
                cnt++;
            end
        end
        check("fill_alu_writes", cnt, 6);

        // WAW kill
        wlog.delete();
        mem_valid = 1; mem_reg = 0; mem_data = 0;
        alu_valid = 1; alu_reg = 5; alu_data = 16'h0001;
        tick();
        alu_valid = 0;
        mem_reg = 5; mem_data = 16'h0002;
        check("waw_pend_before", pend_count, 1);
        tick();
        mem_valid = 0;
        check("waw_squash", squash, 1);
        check("waw_write", write, 1);
        check("waw_sel", writeregsel, 5);
        check("waw_data", writedata, 16'h0002);
        check("waw_pend", pend_count, 0);
        tick();
        check("waw_killed_pop", write, 0);
        check("waw_squash_once", squash, 0);
        idle(3);
        cnt = 0;
        foreach (wlog[i]) begin
            w = wlog[i];
            if (w[RW+DW-1:DW] == 5) cnt++;
        end
        check("waw_reg5_writes", cnt, 1);

        // Reset mid-flight
        wlog.delete();
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_reg = 0; mem_data = 0;
            alu_valid = 1; alu_reg = 6; alu_data = DW'(16'hBEE0 + i);
            tick();
        end
        check("rmf_pend3", pend_count, 3);
        mem_valid = 0; alu_valid = 0; rst = 0;
        tick();
        rst = 1;
        check("rmf_write", write, 0);
        check("rmf_pend", pend_count, 0);
        check("rmf_ready", alu_ready, 1);
        idle(5);
        cnt = 0;
        foreach (wlog[i]) begin
            w = wlog[i];
            if (w[RW+DW-1:DW] == 6) cnt++;
        end
        check("rmf_no_stale", cnt, 0);

        // Protocol violation: drop alu_valid while unaccepted
        check("err_clean", err, 0);
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1; mem_reg = 0; mem_data = 0;
            alu_valid = 1; alu_reg = 7; alu_data = DW'(i);
            tick();
        end
        alu_data = 16'h0099;
        check("err_full_ready", alu_ready, 0);
        tick();
        alu_valid = 0;
        tick();
        check("err_set", err, 1);
        idle(4);
        check("err_sticky", err, 1);
        rst = 0;
        tick();
        rst = 1;
        check("err_cleared", err, 0);
        idle(2);

        // Forwarding
        mem_valid = 1; mem_reg = 0; mem_data = 0;
        alu_valid = 1; alu_reg = 4; alu_data = 16'h0010;
        tick();
        alu_data = 16'h0020;
        tick();
        alu_valid = 0;
        fwd_sel = 4;
        #1;
`ifdef WB_FWD_EN
        check("fwd_hit4", fwd_hit, 1);
        check("fwd_data4", fwd_data, 16'h0020);
`else
        check("fwd_hit_off", fwd_hit, 0);
        check("fwd_data_off", fwd_data, 0);
`endif
        idle(4);

        // Randomized traffic
        held = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!held) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_reg   = RW'($urandom);
                alu_data  = DW'($urandom);
            end else if ($urandom_range(0, 99) < 2) begin
                alu_valid = 0;
            end else if ($urandom_range(0, 99) < 2) begin
                alu_data = DW'($urandom);
            end
            mem_valid = ($urandom_range(0, 99) < 40);
            mem_reg   = RW'($urandom);
            mem_data  = DW'($urandom);
            fwd_sel   = RW'($urandom);
            rst       = ($urandom_range(0, 249) != 0);
            held      = alu_valid && !alu_ready;
            tick();
        end
        rst = 1;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
